// File: rtl/rca_mp_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
// Holds the FSM state encoding, default sizes and the limb-index width helper.
package rca_mp_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int LIMBS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Index width for a limb counter; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rca_mp_add_seq_if.sv
// Request/response bundle for the multi-precision adder sequencer.
// master: drives operands and out_ready; slave: drives in_ready and results.
interface rca_mp_add_seq_if
    import rca_mp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LIMBS = LIMBS_DEF
);

    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH*LIMBS-1:0]   in_a;
    logic [WIDTH*LIMBS-1:0]   in_b;
    logic                     in_cin;
    logic                     in_sub;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH*LIMBS-1:0]   out_sum;
    logic                     out_cout;
    logic                     out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

endinterface

// File: rtl/rca_limb.sv
// Combinational WIDTH-bit ripple-carry adder built from per-bit full adders.
// Ports: x, y, cin in; sum, cout and c_msb_in (carry into the MSB) out.
module rca_limb #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic c;

    always_comb begin
        c        = cin;
        c_msb_in = cin;
        sum      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) begin
                c_msb_in = c;
            end
            sum[i] = x[i] ^ y[i] ^ c;
            c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/rca_mp_add_seq.sv
// Multi-precision add/subtract sequencer reusing one ripple limb adder.
// Ports: clk, reset (sync, high), bus (slave handshake bundle), busy.
module rca_mp_add_seq
    import rca_mp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LIMBS = LIMBS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    rca_mp_add_seq_if.slave  bus,
    output logic             busy
);

    localparam int IDX_W = idx_width(LIMBS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LIMBS - 1);

    state_e state_q, state_d;

    logic [LIMBS-1:0][WIDTH-1:0] a_q, a_d;
    logic [LIMBS-1:0][WIDTH-1:0] b_q, b_d;
    logic [LIMBS-1:0][WIDTH-1:0] sum_q, sum_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        carry_q, carry_d;
    logic                        cout_q, cout_d;
    logic                        ovf_q, ovf_d;

    logic [WIDTH-1:0] limb_x, limb_y, limb_s;
    logic             limb_c, limb_cmsb;

    assign limb_x = a_q[idx_q];
    assign limb_y = b_q[idx_q];

    rca_limb #(.WIDTH(WIDTH)) u_limb (
        .x        (limb_x),
        .y        (limb_y),
        .cin      (carry_q),
        .sum      (limb_s),
        .cout     (limb_c),
        .c_msb_in (limb_cmsb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    // Subtract is A + ~B + 1; in_cin is ignored then.
                    b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
                    carry_d = bus.in_sub | bus.in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = limb_s;
                carry_d      = limb_c;
                if (idx_q == LAST) begin
                    cout_d  = limb_c;
                    ovf_d   = limb_cmsb ^ limb_c;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rca_mp_add_seq.sv
// Scoreboard bench for rca_mp_add_seq with directed vectors.
// Driver pushes expected results; a monitor pops on each output handshake.
module tb_rca_mp_add_seq;
    import rca_mp_pkg::*;

    localparam int W = 64;
    localparam int L = 4;
    localparam int N = W * L;

    typedef struct {
        string        nm;
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    int   tests = 0;
    int   fails = 0;

    rca_mp_add_seq_if #(.WIDTH(W), .LIMBS(L)) bus ();

    rca_mp_add_seq #(.WIDTH(W), .LIMBS(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [N-1:0] act,
                       input logic [N-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string nm, input logic [N-1:0] s,
                              input logic c, input logic o);
        exp_t e;
        e.nm   = nm;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic sub);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", N'(bus.in_ready), N'(1));
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_sub   = sub;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = {8{$urandom}};
        bus.in_b     = {8{$urandom}};
        bus.in_cin   = 1'b0;
        bus.in_sub   = 1'b1;
    endtask

    task automatic wait_valid(input string nm, input int lat);
        int k = 0;
        while (!bus.out_valid && k < 20) begin
            tick();
            k++;
        end
        chk({nm, ".lat"}, N'(k), N'(lat));
    endtask

    task automatic run_op(input string nm,
                          input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin, input logic sub,
                          input logic [N-1:0] s, input logic c,
                          input logic o);
        expect_res(nm, s, c, o);
        send(a, b, cin, sub);
        wait_valid(nm, L);
        tick();
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".in_ready"},  N'(bus.in_ready),  N'(1));
        chk({nm, ".out_valid"}, N'(bus.out_valid), N'(0));
        chk({nm, ".busy"},      N'(busy),          N'(0));
        chk({nm, ".out_sum"},   bus.out_sum,       N'(0));
        chk({nm, ".out_cout"},  N'(bus.out_cout),  N'(0));
        chk({nm, ".out_ovf"},   N'(bus.out_ovf),   N'(0));
    endtask

    // Monitor: compares on every completed output handshake.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got %h want none",
                             bus.out_sum);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.nm, ".sum"},  bus.out_sum,        e.sum);
                    chk({e.nm, ".cout"}, N'(bus.out_cout),  N'(e.cout));
                    chk({e.nm, ".ovf"},  N'(bus.out_ovf),   N'(e.ovf));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : drv
        logic [N-1:0] a5;
        logic [N-1:0] s5;
        int n;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;

        reset = 1'b1;
        repeat (2) tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        run_op("add_wrap", '1, N'(1), 1'b0, 1'b0, '0, 1'b1, 1'b0);
        run_op("add_ovf", {1'b0, {(N-1){1'b1}}}, N'(1), 1'b0, 1'b0,
               {1'b1, {(N-1){1'b0}}}, 1'b0, 1'b1);
        run_op("add_cin", '0, '0, 1'b1, 1'b0, N'(1), 1'b0, 1'b0);
        run_op("sub_neg", N'(5), N'(7), 1'b1, 1'b1,
               {{(N-1){1'b1}}, 1'b0}, 1'b0, 1'b0);
        run_op("sub_pos", N'(7), N'(5), 1'b0, 1'b1, N'(2), 1'b1, 1'b0);
        run_op("sub_ovf", {1'b1, {(N-1){1'b0}}}, N'(1), 1'b0, 1'b1,
               {1'b0, {(N-1){1'b1}}}, 1'b1, 1'b1);

        a5 = {64'h1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        s5 = {64'h1, 64'h1, 64'h0, 64'h0};
        bus.out_ready = 1'b0;
        expect_res("bp", s5, 1'b0, 1'b0);
        send(a5, N'(1), 1'b0, 1'b0);
        wait_valid("bp", L);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            chk("bp.hold_valid", N'(bus.out_valid), N'(1));
            chk("bp.hold_sum",   bus.out_sum,       s5);
            chk("bp.hold_ready", N'(bus.in_ready),  N'(0));
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp.rel_ready", N'(bus.in_ready),  N'(1));
        chk("bp.rel_valid", N'(bus.out_valid), N'(0));
        chk("bp.rel_busy",  N'(busy),          N'(0));

        send('1, N'(1), 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk_reset_vals("abort");
        reset = 1'b0;
        repeat (6) tick();
        chk("abort.no_valid", N'(bus.out_valid), N'(0));

        run_op("add_3_4", N'(3), N'(4), 1'b0, 1'b0, N'(7), 1'b0, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain", N'(exp_q.size()), N'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rca_mp_add_seq.md
Name: rca_mp_add_seq

Overview:
Multi-precision add/subtract sequencer built around a single 64-bit ripple-carry limb adder. It accepts LIMBS*WIDTH-bit operands over a valid/ready handshake and runs them through the limb adder one limb per cycle, LSB limb first, chaining carry between limbs. It returns the full-width result, carry-out and signed overflow over a second valid/ready handshake. It is the controller that lets wide arithmetic (256-bit by default) reuse one 64-bit ripple adder.

Parameters:
WIDTH, 64, limb width in bits (width of the shared ripple adder)
LIMBS, 4, number of limbs per operand; legal range 1..16
IDX_W, $clog2(LIMBS) (min 1), limb index width; derived, not overridden

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept a request
in_a  input  WIDTH*LIMBS  operand A
in_b  input  WIDTH*LIMBS  operand B
in_cin  input  1  carry-in for add; ignored when in_sub=1
in_sub  input  1  1: compute A-B; 0: compute A+B+cin
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH*LIMBS  result
out_cout  output  1  final carry-out (for subtract: 1 = no borrow)
out_ovf  output  1  signed two's-complement overflow
busy  output  1  high in RUN or DONE

Behaviour:
- One clock domain, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, limb index=0, carry reg=0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, in_ready=1, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register A, and B or ~B (if in_sub=1).
  - Set carry reg to in_cin for add, 1 for subtract.
  - Set idx=0 and go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: {c, s} = A[idx] + B'[idx] + carry.
  - Write s into the result limb idx; carry <= c.
  - If idx==LIMBS-1, also capture out_cout=c and out_ovf = (carry into the MSB of the top limb) XOR c. Then go to DONE with out_valid=1.
  - Otherwise idx <= idx+1.
- DONE:
  - out_valid=1. out_sum, out_cout and out_ovf are held stable.
  - On out_ready=1, go to IDLE with out_valid=0 on the next cycle.
  - in_valid is ignored in DONE; there is no same-cycle re-accept.
- Latency: accept on edge N; out_valid is high from edge N+LIMBS. Minimum initiation interval is LIMBS+2 cycles.
- LIMBS=1: a single RUN cycle, then DONE.
- Result limbs are overwritten in place during RUN. out_sum is defined only while out_valid=1. The bench must not check partial limbs.
- Backpressure: out_valid and its data stay stable indefinitely while out_ready=0.
- reset during RUN or DONE: abort the operation and return to reset values on the next edge. No result is emitted.
- reset has priority over every handshake in the same cycle.
- in_valid, in_a and in_b need not be stable after acceptance; they are sampled only on the accept edge.
- Arithmetic is unsigned modulo 2^(WIDTH*LIMBS). out_ovf is the two's-complement signed overflow of the full-width operation.

Decomposition:
- Package rca_mp_pkg holds:
  - the state enum (IDLE, RUN, DONE) with a 2-bit encoding;
  - the default WIDTH/LIMBS constants;
  - a function returning the IDX_W clog2.
- One sub-module, rca_limb: combinational WIDTH-bit ripple-carry adder.
  - Built from per-bit full-adder cells.
  - Inputs x[WIDTH], y[WIDTH], cin. Outputs sum[WIDTH], cout, and c_msb_in (carry into the MSB, needed for overflow).
- The sequencer instantiates exactly one rca_limb and muxes limb idx into it.

Test Plan (WIDTH=64, LIMBS=4):
1. Reset held 2 cycles -> in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, out_ovf=0.
2. Add A=2^256-1, B=1, cin=0 -> out_valid exactly 4 cycles after accept, out_sum=0, out_cout=1, out_ovf=0.
3. Add A=2^255-1, B=1, cin=0 -> out_sum=2^255, out_cout=0, out_ovf=1. Add A=0, B=0, cin=1 -> out_sum=1, out_cout=0.
4. Subtract A=5, B=7 (in_cin=1, ignored) -> out_sum=2^256-2, out_cout=0, out_ovf=0. Subtract A=7, B=5 -> out_sum=2, out_cout=1.
5. Backpressure and exact carry-chain: result {0x1,0x0,0xFFFF_FFFF_FFFF_FFFF,0xFFFF_FFFF_FFFF_FFFF} + 1 held with out_ready=0 for 10 cycles.
   - Expected result: out_sum = limb2 = 0x1, limb1 = 0, limb0 = 0, with limb3 unchanged.
   - While held: out_valid stays 1, data stable, in_ready=0, offered in_valid is not accepted.
   - After out_ready=1: IDLE on the next edge with in_ready=1.
6. reset pulsed while idx=2 of an operation -> next cycle IDLE with all outputs at reset values and no out_valid. The following add 3+4 -> out_sum=7.
